// File: rtl/video_mode_sequencer.sv
// Measures active width/height of the VDP stream, commits a resolution class
// once it has been stable, and blanks output around every mode change.
module video_mode_sequencer #(
  parameter int unsigned STABLE_FRAMES = 2,
  parameter int unsigned MUTE_FRAMES   = 3,
  parameter int unsigned NOSIG_LINES   = 400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       de_h,
  input  logic       hs,
  input  logic       vs,
  output logic [1:0] res_h,
  output logic [1:0] res_v,
  output logic       mode_valid,
  output logic       force_blank,
  output logic       mode_change
);

  localparam int unsigned NW = $clog2(NOSIG_LINES + 1);

  typedef enum logic [1:0] {NOSIG, ACQUIRE, MUTE, LOCKED} state_t;

  state_t        state, state_n;
  logic          hs_q, vs_q;
  logic          line_b, frame_b;
  logic [8:0]    pcnt, wmax, lcnt;
  logic [8:0]    wmax_eff, lcnt_eff;
  logic [NW-1:0] nosig_cnt;
  logic          nosig_hit;
  logic [3:0]    prev, prev_n, cand;
  logic [3:0]    match, match_n;
  logic [3:0]    mute, mute_n;
  logic          restart, commit;

  function automatic logic [1:0] class_h(input logic [8:0] w);
    if (w <= 9'd252) return 2'd0;
    else if (w <= 9'd300) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [1:0] class_v(input logic [8:0] l);
    if (l <= 9'd208) return 2'd0;
    else if (l <= 9'd232) return 2'd1;
    return 2'd2;
  endfunction

  assign line_b    = hs_q & ~hs;
  assign frame_b   = vs_q & ~vs;
  assign nosig_hit = line_b && (nosig_cnt == NW'(NOSIG_LINES - 1));

  // Fold a line finishing in this cycle into the measurement, so a frame
  // boundary coinciding with it still sees the complete frame.
  always_comb begin
    wmax_eff = wmax;
    lcnt_eff = lcnt;
    if (line_b) begin
      if (pcnt > wmax) wmax_eff = pcnt;
      if (pcnt != '0 && lcnt != '1) lcnt_eff = lcnt + 9'd1;
    end
  end

  assign cand = {class_h(wmax_eff), class_v(lcnt_eff)};

  always_comb begin
    state_n = state;
    prev_n  = prev;
    match_n = match;
    mute_n  = mute;
    restart = 1'b0;
    commit  = 1'b0;
    if (nosig_hit) begin
      state_n = NOSIG;
    end else if (frame_b) begin
      unique case (state)
        NOSIG:   restart = (lcnt_eff != '0);
        ACQUIRE: begin
          if (lcnt_eff == '0) begin
            state_n = NOSIG;
          end else begin
            if (cand == prev) match_n = (match == '1) ? match : match + 4'd1;
            else              match_n = 4'd1;
            prev_n = cand;
            commit = (match_n >= 4'(STABLE_FRAMES));
          end
        end
        MUTE: begin
          if (cand != {res_h, res_v}) begin
            restart = 1'b1;
          end else begin
            mute_n = mute - 4'd1;
            if (mute_n == '0) state_n = LOCKED;
          end
        end
        LOCKED:  restart = (cand != {res_h, res_v});
      endcase
      if (restart) begin
        prev_n  = cand;
        match_n = 4'd1;
        state_n = ACQUIRE;
        commit  = (STABLE_FRAMES == 1);
      end
      if (commit) begin
        state_n = MUTE;
        mute_n  = 4'(MUTE_FRAMES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      pcnt        <= '0;
      wmax        <= '0;
      lcnt        <= '0;
      nosig_cnt   <= '0;
      state       <= NOSIG;
      prev        <= '0;
      match       <= '0;
      mute        <= '0;
      res_h       <= '0;
      res_v       <= '0;
      mode_valid  <= 1'b0;
      force_blank <= 1'b1;
      mode_change <= 1'b0;
    end else begin
      hs_q <= hs;
      vs_q <= vs;

      if (line_b)                            pcnt <= '0;
      else if (de_h && ce_pix && pcnt != '1) pcnt <= pcnt + 9'd1;

      if (frame_b) begin
        wmax <= '0;
        lcnt <= '0;
      end else if (line_b) begin
        wmax <= wmax_eff;
        lcnt <= lcnt_eff;
      end

      if (frame_b)
        nosig_cnt <= '0;
      else if (line_b && nosig_cnt != NW'(NOSIG_LINES))
        nosig_cnt <= nosig_cnt + 1'b1;

      state       <= state_n;
      prev        <= prev_n;
      match       <= match_n;
      mute        <= mute_n;
      mode_change <= commit;
      if (commit) {res_h, res_v} <= cand;
      mode_valid  <= (state_n == LOCKED);
      force_blank <= (state_n != LOCKED);
    end
  end

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Bench for video_mode_sequencer: synthetic frames (one wide line, many narrow
// lines) checked against a frame-level reference model.
module tb_video_mode_sequencer;

  localparam int STABLE = 2;
  localparam int MUTEF  = 3;
  localparam int NOSIGL = 400;
  localparam int M_NOSIG = 0, M_ACQ = 1, M_MUTE = 2, M_LOCK = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1, ce_pix = 1'b1, de_h = 1'b0, hs = 1'b1, vs = 1'b1;
  logic [1:0] res_h, res_v;
  logic       mode_valid, force_blank, mode_change;

  int n_checks = 0, n_fail = 0;
  int pulses_seen = 0, frame_pulses = 0;
  logic [5:0] snap;

  int m_st, m_rh, m_rv, m_prev, m_match, m_mute, m_mc, acc_w, acc_n, nos;
  bit nos_hit;

  video_mode_sequencer #(
    .STABLE_FRAMES(STABLE),
    .MUTE_FRAMES(MUTEF),
    .NOSIG_LINES(NOSIGL)
  ) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .de_h(de_h), .hs(hs), .vs(vs),
    .res_h(res_h), .res_v(res_v), .mode_valid(mode_valid),
    .force_blank(force_blank), .mode_change(mode_change)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (mode_change === 1'b1) pulses_seen++;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got still running, required finished");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int cls_h(int w);
    return (w <= 252) ? 0 : (w <= 300) ? 1 : 2;
  endfunction

  function automatic int cls_v(int l);
    return (l <= 208) ? 0 : (l <= 232) ? 1 : 2;
  endfunction

  task automatic m_reset();
    m_st = M_NOSIG; m_rh = 0; m_rv = 0; m_prev = 0; m_match = 0; m_mute = 0;
    m_mc = 0; acc_w = 0; acc_n = 0; nos = 0; nos_hit = 0;
  endtask

  task automatic m_commit(int cand);
    m_rh = cand / 3; m_rv = cand % 3; m_mc = 1; m_st = M_MUTE; m_mute = MUTEF;
  endtask

  task automatic m_restart(int cand);
    m_prev = cand; m_match = 1; m_st = M_ACQ;
    if (m_match >= STABLE) m_commit(cand);
  endtask

  task automatic m_line(int px);
    m_mc = 0;
    if (px > 0 && acc_n < 511) acc_n++;
    if (px > acc_w) acc_w = px;
    if (nos < NOSIGL) begin
      nos++;
      if (nos == NOSIGL) begin m_st = M_NOSIG; nos_hit = 1; end
    end
  endtask

  task automatic m_frame();
    int cand = cls_h(acc_w) * 3 + cls_v(acc_n);
    int committed = m_rh * 3 + m_rv;
    m_mc = 0;
    if (!nos_hit) begin
      case (m_st)
        M_NOSIG: if (acc_n != 0) m_restart(cand);
        M_ACQ: begin
          if (acc_n == 0) m_st = M_NOSIG;
          else begin
            if (cand == m_prev) m_match++;
            else begin m_prev = cand; m_match = 1; end
            if (m_match >= STABLE) m_commit(cand);
          end
        end
        M_MUTE: begin
          if (cand != committed) m_restart(cand);
          else begin
            m_mute--;
            if (m_mute == 0) m_st = M_LOCK;
          end
        end
        default: if (cand != committed) m_restart(cand);
      endcase
    end
    acc_w = 0; acc_n = 0; nos = 0; nos_hit = 0;
  endtask

  function automatic logic [7:0] expv();
    return {m_mc[1:0], m_rh[1:0], m_rv[1:0], (m_st == M_LOCK), (m_st != M_LOCK)};
  endfunction

  function automatic logic [7:0] obsv();
    return {frame_pulses[1:0], snap};
  endfunction

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pixels(int px);
    int cnt = 0;
    de_h = 1'b1;
    while (cnt < px) begin
      ce_pix = ($urandom_range(0, 7) != 0);
      tick();
      if (ce_pix) cnt++;
    end
    de_h = 1'b0;
    ce_pix = 1'b1;
  endtask

  task automatic send_line(int px, bit with_vs);
    drive_pixels(px);
    hs = 1'b0;
    if (with_vs) vs = 1'b0;
    tick();
    m_line(px);
    if (with_vs) begin
      m_frame();
      snap = {res_h, res_v, mode_valid, force_blank};
    end
    nos_hit = 0;
    hs = 1'b1;
    tick();
    if (with_vs) begin vs = 1'b1; tick(); end
  endtask

  task automatic send_vs();
    vs = 1'b0;
    tick();
    m_frame();
    snap = {res_h, res_v, mode_valid, force_blank};
    tick();
    vs = 1'b1;
    tick();
  endtask

  task automatic send_frame(int w, int n, bit coinc, bit wide_last);
    int p0 = pulses_seen;
    int wide = wide_last ? n - 1 : int'($urandom_range(0, n - 1));
    for (int i = 0; i < n; i++)
      send_line((i == wide) ? w : int'($urandom_range(1, 2)), coinc && (i == n - 1));
    if (!coinc) send_vs();
    frame_pulses = pulses_seen - p0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({res_h, res_v, mode_valid, force_blank, mode_change} !== 7'b0000010) begin
      n_fail++;
      $display("FAIL reset_values: got %b required %b",
               {res_h, res_v, mode_valid, force_blank, mode_change}, 7'b0000010);
    end
    reset = 1'b0;
    tick();
    m_reset();
    n_checks++;
    if ({res_h, res_v, mode_valid, force_blank, mode_change} !== 7'b0000010) begin
      n_fail++;
      $display("FAIL reset_release: got %b required %b",
               {res_h, res_v, mode_valid, force_blank, mode_change}, 7'b0000010);
    end
  endtask

  task automatic test_basic_lock();
    int p0 = pulses_seen;
    for (int i = 0; i < 5; i++) begin
      send_frame(320, 224, 1'b0, 1'b0);
      n_checks++;
      if (obsv() !== expv()) begin
        n_fail++;
        $display("FAIL basic_frame%0d: got %b required %b", i + 1, obsv(), expv());
      end
    end
    n_checks++;
    if ({res_h, res_v, mode_valid, force_blank} !== {2'd2, 2'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_locked: got %b required %b",
               {res_h, res_v, mode_valid, force_blank}, {2'd2, 2'd1, 1'b1, 1'b0});
    end
    n_checks++;
    if (pulses_seen - p0 != 1) begin
      n_fail++;
      $display("FAIL basic_pulse_count: got %0d required 1", pulses_seen - p0);
    end
  endtask

  task automatic test_mode_switch();
    for (int i = 0; i < 5; i++) begin
      send_frame(256, 240, 1'b0, 1'b0);
      n_checks++;
      if (obsv() !== expv()) begin
        n_fail++;
        $display("FAIL switch_frame%0d: got %b required %b", i + 1, obsv(), expv());
      end
    end
    n_checks++;
    if ({res_h, res_v, mode_valid, force_blank} !== {2'd1, 2'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL switch_locked: got %b required %b",
               {res_h, res_v, mode_valid, force_blank}, {2'd1, 2'd2, 1'b1, 1'b0});
    end
  endtask

  task automatic test_glitch();
    // first bring it back to 320x224 locked
    for (int i = 0; i < 5; i++) send_frame(320, 224, 1'b0, 1'b0);
    n_checks++;
    if ({res_h, res_v, mode_valid} !== {2'd2, 2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL glitch_setup: got %b required %b", {res_h, res_v, mode_valid}, {2'd2, 2'd1, 1'b1});
    end
    for (int i = 0; i < 6; i++) begin
      send_frame((i == 0) ? 256 : 320, 224, 1'b0, 1'b0);
      n_checks++;
      if (obsv() !== expv() || res_h !== 2'd2) begin
        n_fail++;
        $display("FAIL glitch_frame%0d: got %b required %b", i + 1, obsv(), expv());
      end
    end
    n_checks++;
    if ({res_h, res_v, mode_valid, force_blank} !== {2'd2, 2'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL glitch_relock: got %b required %b",
               {res_h, res_v, mode_valid, force_blank}, {2'd2, 2'd1, 1'b1, 1'b0});
    end
  endtask

  task automatic test_nosig();
    for (int i = 0; i < NOSIGL - 1; i++) send_line(1, 1'b0);
    n_checks++;
    if ({res_h, res_v, mode_valid, force_blank} !== {2'd2, 2'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL nosig_before: got %b required %b",
               {res_h, res_v, mode_valid, force_blank}, {2'd2, 2'd1, 1'b1, 1'b0});
    end
    send_line(1, 1'b0);
    n_checks++;
    if ({res_h, res_v, mode_valid, force_blank} !== {2'd2, 2'd1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL nosig_entered: got %b required %b",
               {res_h, res_v, mode_valid, force_blank}, {2'd2, 2'd1, 1'b0, 1'b1});
    end
  endtask

  task automatic test_reset_in_mute();
    int p0;
    send_vs();
    for (int i = 0; i < 2; i++) send_frame(320, 224, 1'b0, 1'b0);
    n_checks++;
    if (obsv() !== expv() || force_blank !== 1'b1 || m_st != M_MUTE) begin
      n_fail++;
      $display("FAIL mute_setup: got %b fb %b required %b fb 1", obsv(), force_blank, expv());
    end
    p0 = pulses_seen;
    reset = 1'b1;
    tick();
    n_checks++;
    if ({res_h, res_v, mode_valid, force_blank, mode_change} !== 7'b0000010) begin
      n_fail++;
      $display("FAIL mute_reset: got %b required %b",
               {res_h, res_v, mode_valid, force_blank, mode_change}, 7'b0000010);
    end
    reset = 1'b0;
    m_reset();
    repeat (3) tick();
    n_checks++;
    if ({res_h, res_v, mode_valid, force_blank} !== 6'b000001 || pulses_seen != p0) begin
      n_fail++;
      $display("FAIL mute_after_reset: got %b pulses %0d required 000001 pulses 0",
               {res_h, res_v, mode_valid, force_blank}, pulses_seen - p0);
    end
  endtask

  task automatic test_coincident();
    // 209 lines and a 253 px final line only classify as 1 if the last line is counted
    for (int i = 0; i < 2; i++) begin
      send_frame(253, 209, 1'b1, 1'b1);
      n_checks++;
      if (obsv() !== expv()) begin
        n_fail++;
        $display("FAIL coinc_frame%0d: got %b required %b", i + 1, obsv(), expv());
      end
    end
    n_checks++;
    if ({res_h, res_v, mode_valid, force_blank} !== {2'd1, 2'd1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL coinc_commit: got %b required %b",
               {res_h, res_v, mode_valid, force_blank}, {2'd1, 2'd1, 1'b0, 1'b1});
    end
  endtask

  task automatic test_random();
    int ws[6] = '{200, 252, 253, 300, 301, 320};
    int ls[5] = '{150, 208, 209, 232, 233};
    int fr = 0;
    for (int g = 0; g < 10; g++) begin
      int w = ws[$urandom_range(0, 5)];
      int n = ls[$urandom_range(0, 4)];
      int reps = $urandom_range(1, 3);
      for (int r = 0; r < reps; r++) begin
        send_frame(w, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        fr++;
        n_checks++;
        if (obsv() !== expv()) begin
          n_fail++;
          $display("FAIL random_frame%0d (%0dx%0d): got %b required %b", fr, w, n, obsv(), expv());
        end
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_basic_lock();
    test_mode_switch();
    test_glitch();
    test_nosig();
    test_reset_in_mute();
    test_coincident();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
